// File: rtl/io_pkg.sv
// Shared IO-bus types: arbiter states, default bus widths, requester bundle.
// Latency: n/a (types only).  Backpressure: n/a.
package io_pkg;

    localparam int IO_AWIDTH = 10;
    localparam int IO_DWIDTH = 32;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    typedef struct packed {
        logic [IO_AWIDTH-1:0]   addr;
        logic [IO_DWIDTH-1:0]   din;
        logic [IO_DWIDTH/8-1:0] wbe;
    } io_req_t;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Two-requester IO bus: master modport is the arbiter, slave modport is requesters plus IO controller.
// Latency: grant combinational, read data 1 cycle after grant.  Backpressure: req held until gnt.
interface io_bus_arbiter_if #(
    parameter int DWIDTH = io_pkg::IO_DWIDTH,
    parameter int AWIDTH = io_pkg::IO_AWIDTH
);
    logic                m0_req;
    logic                m0_lock;
    logic [AWIDTH-1:0]   m0_addr;
    logic [DWIDTH-1:0]   m0_din;
    logic [DWIDTH/8-1:0] m0_wbe;
    logic                m0_gnt;
    logic                m0_rvalid;
    logic [DWIDTH-1:0]   m0_dout;

    logic                m1_req;
    logic                m1_lock;
    logic [AWIDTH-1:0]   m1_addr;
    logic [DWIDTH-1:0]   m1_din;
    logic [DWIDTH/8-1:0] m1_wbe;
    logic                m1_gnt;
    logic                m1_rvalid;
    logic [DWIDTH-1:0]   m1_dout;

    logic                s_en;
    logic [AWIDTH-1:0]   s_addr;
    logic [DWIDTH-1:0]   s_din;
    logic [DWIDTH/8-1:0] s_wbe;
    logic [DWIDTH-1:0]   s_dout;

    modport master (
        input  m0_req, m0_lock, m0_addr, m0_din, m0_wbe,
        output m0_gnt, m0_rvalid, m0_dout,
        input  m1_req, m1_lock, m1_addr, m1_din, m1_wbe,
        output m1_gnt, m1_rvalid, m1_dout,
        output s_en, s_addr, s_din, s_wbe,
        input  s_dout
    );

    modport slave (
        output m0_req, m0_lock, m0_addr, m0_din, m0_wbe,
        input  m0_gnt, m0_rvalid, m0_dout,
        output m1_req, m1_lock, m1_addr, m1_din, m1_wbe,
        input  m1_gnt, m1_rvalid, m1_dout,
        input  s_en, s_addr, s_din, s_wbe,
        output s_dout
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: ptr selects the preferred requester when both are asking.
// Latency: purely combinational.  Backpressure: none, a lone request always wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !ptr)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter with ownership lock in front of the IO controller slave port.
// Latency: grant same cycle as req, read data 1 cycle later; losers stall with gnt=0.
// Optional lock watchdog: IO_ARB_LOCK_WATCHDOG_EN (breaks a lock after LOCK_MAX cycles).
module io_bus_arbiter #(
    parameter int DWIDTH   = io_pkg::IO_DWIDTH,
    parameter int AWIDTH   = io_pkg::IO_AWIDTH,
    parameter int LOCK_MAX = 64
) (
    input  logic              clk,
    input  logic              rst,
    io_bus_arbiter_if.master  bus,
    output logic              lock_err
);
    import io_pkg::*;

    localparam int BW = DWIDTH / 8;

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] din;
        logic [BW-1:0]     wbe;
    } req_t;

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic       rsel_q, rsel_d;
    logic       rvld_q, rvld_d;

    logic [1:0] req_vec;
    logic [1:0] lock_vec;
    logic [1:0] rr_gnt;
    logic [1:0] gnt;
    logic       gnt_idx;
    logic       wd_fire;
    req_t       m_req [2];
    req_t       sel_req;

    assign req_vec  = {bus.m1_req, bus.m0_req};
    assign lock_vec = {bus.m1_lock, bus.m0_lock};
    assign m_req[0] = '{addr: bus.m0_addr, din: bus.m0_din, wbe: bus.m0_wbe};
    assign m_req[1] = '{addr: bus.m1_addr, din: bus.m1_din, wbe: bus.m1_wbe};

    rr_arb2 u_rr_arb2 (
        .req (req_vec),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt)
    );

    // Reset gates the grant so the slave strobe drops the moment rst falls.
    always_comb begin
        gnt = 2'b00;
        if (rst) begin
            if (state_q == ARB_IDLE) begin
                gnt = rr_gnt;
            end else begin
                gnt[owner_q] = req_vec[owner_q];
            end
        end
    end

    assign gnt_idx = gnt[1];

    always_comb begin
        sel_req = '0;
        if (gnt[0]) begin
            sel_req = m_req[0];
        end else if (gnt[1]) begin
            sel_req = m_req[1];
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        rsel_d   = gnt_idx;
        rvld_d   = (|gnt) && (sel_req.wbe == '0);
        case (state_q)
            ARB_IDLE: begin
                if (|gnt) begin
                    rr_ptr_d = ~gnt_idx;
                    if (lock_vec[gnt_idx]) begin
                        state_d = ARB_LOCKED;
                        owner_d = gnt_idx;
                    end
                end
            end
            ARB_LOCKED: begin
                // Owner traffic leaves the pointer alone; a broken lock hands priority away.
                if (!lock_vec[owner_q]) begin
                    state_d = ARB_IDLE;
                end else if (wd_fire) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = ~owner_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            rsel_q   <= 1'b0;
            rvld_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            rsel_q   <= rsel_d;
            rvld_q   <= rvld_d;
        end
    end

`ifdef IO_ARB_LOCK_WATCHDOG_EN
    localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             lock_err_q, lock_err_d;

    always_comb begin
        lock_cnt_d = '0;
        lock_err_d = 1'b0;
        wd_fire    = 1'b0;
        if (state_q == ARB_LOCKED && lock_vec[owner_q]) begin
            if (lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                wd_fire    = 1'b1;
                lock_err_d = 1'b1;
            end else begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_cnt_q <= '0;
            lock_err_q <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign lock_err = lock_err_q;
`else
    assign wd_fire  = 1'b0;
    assign lock_err = 1'b0;
`endif

    assign bus.m0_gnt    = gnt[0];
    assign bus.m1_gnt    = gnt[1];
    assign bus.s_en      = |gnt;
    assign bus.s_addr    = sel_req.addr;
    assign bus.s_din     = sel_req.din;
    assign bus.s_wbe     = sel_req.wbe;
    assign bus.m0_rvalid = rvld_q & ~rsel_q;
    assign bus.m1_rvalid = rvld_q & rsel_q;
    assign bus.m0_dout   = bus.s_dout;
    assign bus.m1_dout   = bus.s_dout;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: grants checked as driven, read data via a scoreboard queue.
module tb_io_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic lock_err;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    typedef struct {
        int          cyc;
        logic        m;
        logic [31:0] d;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] smem    [1024];
    logic [31:0] exp_mem [1024];

    io_bus_arbiter_if #(.DWIDTH(32), .AWIDTH(10)) bus ();

    io_bus_arbiter #(.DWIDTH(32), .AWIDTH(10), .LOCK_MAX(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .lock_err (lock_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // IO controller model: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.s_en) begin
            if (bus.s_wbe == 4'h0) begin
                bus.s_dout <= smem[bus.s_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.s_wbe[b]) smem[bus.s_addr][8*b +: 8] <= bus.s_din[8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [1:0]  exp_v;
        logic [31:0] exp_d;
        exp_v = 2'b00;
        exp_d = '0;
        if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
            e     = sb.pop_front();
            exp_v = e.m ? 2'b10 : 2'b01;
            exp_d = e.d;
        end
        check("rvalid", {62'd0, bus.m1_rvalid, bus.m0_rvalid}, {62'd0, exp_v});
        if (exp_v != 2'b00) begin
            check("m0_dout", bus.m0_dout, exp_d);
            check("m1_dout", bus.m1_dout, exp_d);
        end
    end

    task automatic set_m(input int m, input logic req, input logic lock, input logic [9:0] a,
                         input logic [31:0] d, input logic [3:0] w);
        if (m == 0) begin
            bus.m0_req = req; bus.m0_lock = lock; bus.m0_addr = a; bus.m0_din = d; bus.m0_wbe = w;
        end else begin
            bus.m1_req = req; bus.m1_lock = lock; bus.m1_addr = a; bus.m1_din = d; bus.m1_wbe = w;
        end
    endtask

    // Checks the grant expected for the inputs just driven; queues the read data it implies.
    task automatic step(input string tag, input logic eg0, input logic eg1, input bit track = 1'b1);
        logic [9:0]  a;
        logic [31:0] d;
        logic [3:0]  w;
        #1;
        check({tag, ":m0_gnt"}, bus.m0_gnt, eg0);
        check({tag, ":m1_gnt"}, bus.m1_gnt, eg1);
        check({tag, ":s_en"}, bus.s_en, eg0 | eg1);
        a = eg1 ? bus.m1_addr : bus.m0_addr;
        d = eg1 ? bus.m1_din  : bus.m0_din;
        w = eg1 ? bus.m1_wbe  : bus.m0_wbe;
        if (eg0 | eg1) begin
            check({tag, ":s_addr"}, bus.s_addr, a);
            check({tag, ":s_din"}, bus.s_din, d);
            check({tag, ":s_wbe"}, bus.s_wbe, w);
            if (w == 4'h0) begin
                if (track) sb.push_back('{cyc: cyc, m: eg1, d: exp_mem[a]});
            end else begin
                for (int b = 0; b < 4; b++) if (w[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
            end
        end else begin
            check({tag, ":s_addr_idle"}, bus.s_addr, 10'h000);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            smem[i]    = 32'hA500_0000 ^ (i * 32'h0001_0101);
            exp_mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0101);
        end
        smem[8]    = 32'h0000_000A;
        exp_mem[8] = 32'h0000_000A;
        bus.s_dout = '0;
        set_m(0, 1'b1, 1'b0, 10'h008, 32'h0, 4'h0);
        set_m(1, 1'b1, 1'b0, 10'h020, 32'h0, 4'h0);

        // Reset holds everything quiet even with requests pending.
        @(negedge clk);
        step("reset", 1'b0, 1'b0);
        check("reset:lock_err", lock_err, 1'b0);

        // Single read from m0.
        @(negedge clk); rst = 1'b1;
        set_m(1, 1'b0, 1'b0, 10'h020, 32'h0, 4'h0);
        step("rd0", 1'b1, 1'b0);
        @(negedge clk); set_m(0, 1'b0, 1'b0, 10'h008, 32'h0, 4'h0);
        step("idle0", 1'b0, 1'b0);

        // m1 read moves the pointer back to m0, then contention alternates.
        @(negedge clk); set_m(1, 1'b1, 1'b0, 10'h003, 32'h0, 4'h0);
        step("rd1", 1'b0, 1'b1);
        @(negedge clk);
        set_m(0, 1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
        set_m(1, 1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            step($sformatf("cont%0d", i), (i % 2) == 0, (i % 2) == 1);
        end

        // Write produces no response; the read-back sees the new byte.
        @(negedge clk);
        set_m(0, 1'b0, 1'b0, 10'h010, 32'h0, 4'h0);
        set_m(1, 1'b1, 1'b0, 10'h008, 32'h5, 4'h1);
        step("wr1", 1'b0, 1'b1);
        @(negedge clk);
        set_m(1, 1'b0, 1'b0, 10'h008, 32'h0, 4'h0);
        set_m(0, 1'b1, 1'b0, 10'h008, 32'h0, 4'h0);
        step("rdback", 1'b1, 1'b0);

        // m1 locks the port for a read-modify-write while m0 waits.
        @(negedge clk);
        set_m(0, 1'b1, 1'b0, 10'h030, 32'h0, 4'h0);
        set_m(1, 1'b1, 1'b1, 10'h040, 32'h0, 4'h0);
        step("lk_rd", 1'b0, 1'b1);
        @(negedge clk); set_m(1, 1'b0, 1'b1, 10'h040, 32'h0, 4'h0);
        step("lk_gap", 1'b0, 1'b0);
        @(negedge clk); set_m(1, 1'b1, 1'b1, 10'h040, 32'h1234, 4'hF);
        step("lk_wr", 1'b0, 1'b1);
        @(negedge clk); set_m(1, 1'b1, 1'b0, 10'h040, 32'h0, 4'h0);
        step("lk_last", 1'b0, 1'b1);
        @(negedge clk); set_m(1, 1'b0, 1'b0, 10'h040, 32'h0, 4'h0);
        step("lk_rel", 1'b1, 1'b0);

        // Async reset between grant and response discards the read and resets the pointer.
        @(negedge clk); set_m(0, 1'b1, 1'b0, 10'h050, 32'h0, 4'h0);
        step("rst_rd", 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        set_m(1, 1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
        @(negedge clk);
        step("rst_hold", 1'b0, 1'b0);
        @(negedge clk); rst = 1'b1;
        step("rst_rel", 1'b1, 1'b0);

        // Reset while m1 holds a lock drops the lock.
        @(negedge clk); set_m(0, 1'b0, 1'b0, 10'h050, 32'h0, 4'h0);
        set_m(1, 1'b1, 1'b1, 10'h020, 32'h0, 4'h0);
        step("rst_lk", 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        step("rst_lk_hold", 1'b0, 1'b0);
        @(negedge clk); rst = 1'b1;
        set_m(0, 1'b1, 1'b0, 10'h050, 32'h0, 4'h0);
        set_m(1, 1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
        step("rst_lk_rel", 1'b1, 1'b0);
        @(negedge clk); set_m(0, 1'b0, 1'b0, 10'h050, 32'h0, 4'h0);
        step("pre_wd", 1'b0, 1'b1);

        // m0 holds its lock while m1 keeps requesting.
        @(negedge clk);
        set_m(0, 1'b1, 1'b1, 10'h030, 32'h0, 4'h0);
        set_m(1, 1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            logic wd_hit;
            if (i > 0) @(negedge clk);
`ifdef IO_ARB_LOCK_WATCHDOG_EN
            wd_hit = (i == 9);
`else
            wd_hit = 1'b0;
`endif
            step($sformatf("wd%0d", i), !wd_hit, wd_hit);
            check($sformatf("wd%0d:lock_err", i), lock_err, wd_hit);
        end
        @(negedge clk);
        set_m(0, 1'b1, 1'b0, 10'h030, 32'h0, 4'h0);
        set_m(1, 1'b0, 1'b0, 10'h020, 32'h0, 4'h0);
        step("wd_after", 1'b1, 1'b0);
        check("wd_after:lock_err", lock_err, 1'b0);
        @(negedge clk); set_m(0, 1'b0, 1'b0, 10'h030, 32'h0, 4'h0);
        step("end_idle", 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #2;
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
